// File: rtl/add_sum_acc_if.sv
// Handshake bundle between the adder stage, the block accumulator and the
// downstream block reporter.
interface add_sum_acc_if #(
   parameter int SUM_W = 5,
   parameter int ACC_W = 8
);
   logic             clr;
   logic [SUM_W-1:0] sum_in;
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] acc_out;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output clr, sum_in, in_valid, out_ready,
      input  in_ready, acc_out, ovf, out_valid
   );

   modport slave (
      input  clr, sum_in, in_valid, out_ready,
      output in_ready, acc_out, ovf, out_valid
   );
endinterface

// File: rtl/add_sum_acc.sv
// Accumulates BLK_LEN accepted sums into a block total with a carry flag.
// Define ADD_SUM_ACC_SAT_EN to saturate the running total instead of wrapping.
module add_sum_acc #(
   parameter int SUM_W   = 5,
   parameter int ACC_W   = 8,
   parameter int BLK_LEN = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   add_sum_acc_if.slave   bus
);
   typedef enum logic {S_ACC, S_HOLD} state_t;

   localparam logic [7:0] LAST_IDX = 8'(BLK_LEN - 1);

   state_t           state_q;
   logic [ACC_W-1:0] acc_q;
   logic [7:0]       cnt_q;
   logic             ovf_int_q;
   logic [ACC_W-1:0] acc_out_q;
   logic             ovf_q;
   logic             out_valid_q;

   logic [ACC_W:0]   sum_w;
   logic             carry_w;
   logic [ACC_W-1:0] acc_d;
   logic             ovf_int_d;
   logic             accept_w;
   logic             last_w;

   assign sum_w     = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, bus.sum_in};
   assign carry_w   = sum_w[ACC_W];
   assign ovf_int_d = ovf_int_q | carry_w;

`ifdef ADD_SUM_ACC_SAT_EN
   // Once saturated, any non-zero add carries again, so the total stays pinned.
   assign acc_d = carry_w ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
   assign acc_d = sum_w[ACC_W-1:0];
`endif

   assign bus.in_ready = (state_q == S_ACC) || bus.out_ready;
   assign accept_w     = bus.in_valid && bus.in_ready;
   assign last_w       = (cnt_q == LAST_IDX);

   assign bus.acc_out   = acc_out_q;
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = out_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_int_q   <= 1'b0;
         acc_out_q   <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (bus.clr) begin
         state_q     <= S_ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_int_q   <= 1'b0;
         acc_out_q   <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_ACC;
         end
         // A completing block overrides the handshake release above (no bubble).
         if (accept_w) begin
            if (last_w) begin
               acc_out_q   <= acc_d;
               ovf_q       <= ovf_int_d;
               out_valid_q <= 1'b1;
               state_q     <= S_HOLD;
               acc_q       <= '0;
               cnt_q       <= '0;
               ovf_int_q   <= 1'b0;
            end else begin
               acc_q       <= acc_d;
               cnt_q       <= cnt_q + 8'd1;
               ovf_int_q   <= ovf_int_d;
            end
         end
      end
   end
endmodule
